serv_mem_if_par: RTL and testbench
==================================

SERV_MEM_IF_PAR -- requirements
Module: serv_mem_if_par

Interface
REQ-001 SHALL have parameter W, default 1: serial datapath width in bits per cycle; legal values 1, 2, 4. N = 32/W beats per word.
REQ-002 SHALL have parameter TIMEOUT, default 0: bus timeout in cycles; 0 disables the timeout.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1 bit: starts an operation; sampled only in IDLE; the start cycle is beat 0.
REQ-006 SHALL have port i_we, input, 1 bit: 1 = store, 0 = load; sampled with i_start.
REQ-007 SHALL have port i_funct3, input, 3 bits: [1:0] size (00 byte, 01 half, 1x word); [2] = 1 selects unsigned load; held stable during the operation.
REQ-008 SHALL have ports i_rs1 and i_imm, input, W bits each: address operands, serial LSB-first, one W-bit slice per beat.
REQ-009 SHALL have port i_rs2, input, W bits: store data, serial LSB-first, same beats as the address.
REQ-010 SHALL have port o_rd, output, W bits: load result, serial LSB-first.
REQ-011 SHALL have port o_rd_valid, output, 1 bit: high on each o_rd beat.
REQ-012 SHALL have ports o_busy, o_done, o_misalign and o_err, output, 1 bit each: busy status, one-cycle completion pulse, misalignment flag, bus error/timeout flag.
REQ-013 SHALL have the Wishbone master ports o_wb_adr[31:0], o_wb_dat[31:0], o_wb_sel[3:0], o_wb_we and o_wb_cyc (outputs), and i_wb_rdt[31:0], i_wb_ack and i_wb_err (inputs).

Function
REQ-014 SHALL implement a state machine with states IDLE, ADDR, BUS and RESULT.
REQ-015 IDLE to ADDR SHALL occur on i_start; beats 0..N-1 occupy N consecutive cycles starting at the i_start cycle.
REQ-016 In ADDR, each beat SHALL add i_rs1 + i_imm + carry to form W address bits, using a carry register that is cleared at beat 0; overflow out of bit 31 SHALL be discarded.
REQ-017 In ADDR, each beat SHALL shift i_rs2 into a 32-bit data register.
REQ-018 When ADDR ends, the block SHALL check alignment: a half access with adr[0]=1, or a word access with adr[1:0]!=0, is misaligned.
REQ-019 On misalignment: o_misalign=1 and a one-cycle o_done pulse SHALL be produced, the state SHALL return to IDLE, and no bus cycle SHALL be issued.
REQ-020 If aligned, the state SHALL be BUS and o_wb_cyc SHALL be 1 from the cycle after beat N-1.
REQ-021 o_wb_adr SHALL be {adr[31:2], 2'b00}; o_wb_we SHALL equal the latched i_we.
REQ-022 o_wb_sel SHALL be 1111 for word, 0011 or 1100 for half (selected by adr[1]), and 0001<<adr[1:0] for byte.
REQ-023 o_wb_dat SHALL replicate store data: byte = 4 copies of bits[7:0]; half = 2 copies of bits[15:0]; word unchanged.
REQ-024 o_wb_cyc SHALL stay high until i_wb_ack, i_wb_err or timeout, and SHALL drop the following cycle.
REQ-025 If i_wb_ack and i_wb_err are both high, i_wb_err SHALL win.
REQ-026 On i_wb_err, or when TIMEOUT>0 and o_wb_cyc has been high for TIMEOUT cycles: o_err=1, o_done pulse, return to IDLE, no RESULT phase.
REQ-027 On a store ack: o_done SHALL pulse in the next cycle, then IDLE.
REQ-028 On a load ack: i_wb_rdt SHALL be captured, the state SHALL be RESULT for N beats with o_rd_valid=1, and o_done SHALL pulse in the cycle after the last beat.
REQ-029 The load result SHALL be the lane selected by adr[1:0] and size, right-aligned, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to 32 bits, and output LSB-first.
REQ-030 o_busy SHALL be 1 in every state except IDLE.
REQ-031 i_start SHALL be ignored while o_busy=1.
REQ-032 o_misalign and o_err SHALL hold their value until the next accepted i_start, which clears them.
REQ-033 o_rd SHALL be 0 whenever o_rd_valid=0.

Reset
REQ-034 While i_rst=1, at the next edge: state=IDLE; o_wb_cyc, o_busy, o_done, o_rd_valid, o_misalign, o_err and o_rd SHALL all be 0; the carry and timeout counter SHALL be cleared.
REQ-035 Reset asserted in any state, including BUS with an outstanding cycle, SHALL abort the operation; an ack arriving after reset SHALL be ignored.
REQ-036 The address and data registers SHALL need no reset value.

Verification
REQ-037 Byte load, W=1: rs1=0x1000, imm=3, funct3=000, rdt=0x80112233 -> o_wb_adr=0x1000, o_wb_sel=1000, o_rd serial = 0xFFFFFF80 over 32 beats, then o_done.
REQ-038 Half store, W=4: rs1=0x2000, imm=2, rs2=0x0000BEEF -> o_wb_sel=1100, o_wb_dat=0xBEEFBEEF, o_wb_cyc rises at cycle 8, and o_done the cycle after ack.
REQ-039 Misaligned word, W=2: rs1=0x100, imm=1, funct3=010 -> o_misalign=1, o_done pulse, and o_wb_cyc never high.
REQ-040 Error and timeout: ack and err together -> o_err=1 with no o_rd_valid; with TIMEOUT=16 and no ack -> o_wb_cyc high exactly 16 cycles, then o_err=1.
REQ-041 Reset mid-BUS, then a late ack -> o_wb_cyc=0 the cycle after reset, the state stays IDLE, and o_done never pulses.
REQ-042 A second i_start during RESULT is ignored; an unsigned half load (funct3=101) with rdt=0xF00D8001 at adr[1]=1 -> o_rd = 0x0000F00D.

Source files
------------

// File: rtl/serv_mem_if_par.sv
// rtl/serv_mem_if_par.sv - bit-serial load/store unit with a Wishbone master
//
// Takes a serial address (rs1 + imm) and serial store data W bits per beat.
// It issues one single-beat Wishbone cycle, then returns load data serially.
//
// Parameters
//   W        serial width per beat (1, 2 or 4); N = 32/W beats per word
//   TIMEOUT  bus timeout in cycles, 0 disables it
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start, i_we         start request (IDLE only) and store/load select
//   i_funct3              [1:0] size (00 byte, 01 half, 1x word), [2] unsigned load
//   i_rs1, i_imm, i_rs2   serial address operands and store data, LSB first
//   o_rd, o_rd_valid      serial load result, LSB first, and its beat strobe
//   o_busy, o_done        not-idle status, one-cycle completion pulse
//   o_misalign, o_err     sticky until next start: misaligned access, bus error/timeout
//   o_wb_*, i_wb_*        Wishbone master
module serv_mem_if_par #(
  parameter int W       = 1,
  parameter int TIMEOUT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [2:0]    i_funct3,
  input  logic [W-1:0]  i_rs1,
  input  logic [W-1:0]  i_imm,
  input  logic [W-1:0]  i_rs2,
  output logic [W-1:0]  o_rd,
  output logic          o_rd_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_misalign,
  output logic          o_err,
  output logic [31:0]   o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  input  logic          i_wb_err
);

  localparam int         N         = 32 / W;
  localparam logic [5:0] LAST_BEAT = 6'(N - 1);
  localparam logic [31:0] TO_LAST  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {IDLE, ADDR, BUS, RESULT} state_t;

  state_t      state;
  logic [5:0]  beat;
  logic        carry;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [31:0] res;
  logic [31:0] to_cnt;
  logic [2:0]  f3;
  logic        we;

  logic        cin;
  logic [W:0]  sum;
  logic [31:0] adr_nxt;
  logic        misal;
  logic [15:0] lane;
  logic [31:0] ld_val;
  logic        to_hit;

  always_comb begin
    // Carry starts fresh on beat 0, which is the IDLE/start cycle.
    cin     = (state == IDLE) ? 1'b0 : carry;
    sum     = {1'b0, i_rs1} + {1'b0, i_imm} + {{W{1'b0}}, cin};
    // Address fills from the top so beat 0 ends up at bit 0 after N shifts.
    adr_nxt = {sum[W-1:0], adr[31:W]};
    misal   = f3[1] ? (adr_nxt[1:0] != 2'b00) : (f3[0] & adr_nxt[0]);

    // Selected byte/half lane, right-aligned, then sign- or zero-extended.
    lane = 16'(i_wb_rdt >> {adr[1:0], 3'b000});
    if (f3[1])
      ld_val = i_wb_rdt;
    else if (f3[0])
      ld_val = {{16{~f3[2] & lane[15]}}, lane[15:0]};
    else
      ld_val = {{24{~f3[2] & lane[7]}}, lane[7:0]};

    to_hit = (TIMEOUT > 0) && (to_cnt == TO_LAST);
  end

  always_comb begin
    o_wb_sel = 4'b0000;
    if (f3[1])
      o_wb_sel = 4'b1111;
    else if (f3[0])
      o_wb_sel = adr[1] ? 4'b1100 : 4'b0011;
    else
      o_wb_sel = 4'b0001 << adr[1:0];
  end

  assign o_wb_adr = {adr[31:2], 2'b00};
  assign o_wb_dat = f3[1] ? dat : (f3[0] ? {2{dat[15:0]}} : {4{dat[7:0]}});
  assign o_wb_we  = we;
  assign o_busy   = (state != IDLE);
  assign o_rd     = o_rd_valid ? res[W-1:0] : '0;

  always_ff @(posedge i_clk) begin
    o_done <= 1'b0;
    if (i_rst) begin
      state      <= IDLE;
      o_wb_cyc   <= 1'b0;
      o_rd_valid <= 1'b0;
      o_misalign <= 1'b0;
      o_err      <= 1'b0;
      carry      <= 1'b0;
      to_cnt     <= 32'd0;
      beat       <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            we         <= i_we;
            f3         <= i_funct3;
            o_misalign <= 1'b0;
            o_err      <= 1'b0;
            adr        <= adr_nxt;
            dat        <= {i_rs2, dat[31:W]};
            carry      <= sum[W];
            beat       <= 6'd1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          adr   <= adr_nxt;
          dat   <= {i_rs2, dat[31:W]};
          carry <= sum[W];
          beat  <= beat + 6'd1;
          if (beat == LAST_BEAT) begin
            if (misal) begin
              o_misalign <= 1'b1;
              o_done     <= 1'b1;
              state      <= IDLE;
            end else begin
              o_wb_cyc <= 1'b1;
              to_cnt   <= 32'd0;
              state    <= BUS;
            end
          end
        end
        BUS: begin
          // Error outranks a simultaneous ack.
          if (i_wb_err || to_hit) begin
            o_wb_cyc <= 1'b0;
            o_err    <= 1'b1;
            o_done   <= 1'b1;
            state    <= IDLE;
          end else if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            if (we) begin
              o_done <= 1'b1;
              state  <= IDLE;
            end else begin
              res        <= ld_val;
              o_rd_valid <= 1'b1;
              beat       <= 6'd0;
              state      <= RESULT;
            end
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        RESULT: begin
          res  <= {{W{1'b0}}, res[31:W]};
          beat <= beat + 6'd1;
          if (beat == LAST_BEAT) begin
            o_rd_valid <= 1'b0;
            o_done     <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_mem_if_par.sv
// tb/tb_serv_mem_if_par.sv - directed scoreboard bench for serv_mem_if_par
module tb_serv_mem_if_par;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a [3];
  logic        we_a    [3];
  logic        ack_a   [3];
  logic        err_a   [3];
  logic [2:0]  f3_a    [3];
  logic [3:0]  rs1_a   [3];
  logic [3:0]  imm_a   [3];
  logic [3:0]  rs2_a   [3];
  logic [31:0] rdt_a   [3];

  wire  [3:0]  rd_a    [3];
  wire         rdv_a   [3];
  wire         busy_a  [3];
  wire         done_a  [3];
  wire         mis_a   [3];
  wire         berr_a  [3];
  wire         cyc_a   [3];
  wire         wwe_a   [3];
  wire  [31:0] adr_a   [3];
  wire  [31:0] dat_a   [3];
  wire  [3:0]  sel_a   [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // Instance 0: W=1, instance 1: W=4 with TIMEOUT=16, instance 2: W=2.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WG = (g == 0) ? 1 : ((g == 1) ? 4 : 2);
    localparam int TG = (g == 1) ? 16 : 0;
    logic [WG-1:0] rd_w;
    logic rdv_w, busy_w, done_w, mis_w, err_w, cyc_w, we_w;
    logic [31:0] adr_w, dat_w;
    logic [3:0]  sel_w;
    serv_mem_if_par #(.W(WG), .TIMEOUT(TG)) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start_a[g]),
      .i_we       (we_a[g]),
      .i_funct3   (f3_a[g]),
      .i_rs1      (rs1_a[g][WG-1:0]),
      .i_imm      (imm_a[g][WG-1:0]),
      .i_rs2      (rs2_a[g][WG-1:0]),
      .o_rd       (rd_w),
      .o_rd_valid (rdv_w),
      .o_busy     (busy_w),
      .o_done     (done_w),
      .o_misalign (mis_w),
      .o_err      (err_w),
      .o_wb_adr   (adr_w),
      .o_wb_dat   (dat_w),
      .o_wb_sel   (sel_w),
      .o_wb_we    (we_w),
      .o_wb_cyc   (cyc_w),
      .i_wb_rdt   (rdt_a[g]),
      .i_wb_ack   (ack_a[g]),
      .i_wb_err   (err_a[g])
    );
    assign rd_a[g]   = 4'(rd_w);
    assign rdv_a[g]  = rdv_w;
    assign busy_a[g] = busy_w;
    assign done_a[g] = done_w;
    assign mis_a[g]  = mis_w;
    assign berr_a[g] = err_w;
    assign cyc_a[g]  = cyc_w;
    assign wwe_a[g]  = we_w;
    assign adr_a[g]  = adr_w;
    assign dat_a[g]  = dat_w;
    assign sel_a[g]  = sel_w;
  end

  function automatic int wd(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk(tag, obs, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation, N beats starting with the i_start cycle.
  task automatic drive_op(input int k, input logic we, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] rs2, output logic seen_cyc);
    int w = wd(k);
    int n = 32 / w;
    logic [31:0] m = (32'd1 << w) - 32'd1;
    seen_cyc = 1'b0;
    for (int b = 0; b < n; b++) begin
      start_a[k] = (b == 0);
      we_a[k]    = we;
      f3_a[k]    = f3;
      rs1_a[k]   = 4'((rs1 >> (b * w)) & m);
      imm_a[k]   = 4'((imm >> (b * w)) & m);
      rs2_a[k]   = 4'((rs2 >> (b * w)) & m);
      @(negedge clk);
      seen_cyc = seen_cyc | cyc_a[k];
      tick();
    end
    start_a[k] = 1'b0;
    rs1_a[k] = 4'd0;
    imm_a[k] = 4'd0;
    rs2_a[k] = 4'd0;
  endtask

  task automatic respond(input int k, input logic ack, input logic err, input logic [31:0] rdt);
    ack_a[k] = ack;
    err_a[k] = err;
    rdt_a[k] = rdt;
    tick();
    ack_a[k] = 1'b0;
    err_a[k] = 1'b0;
  endtask

  task automatic collect(input int k, output logic [31:0] val, output logic all_valid);
    int w = wd(k);
    int n = 32 / w;
    logic [31:0] m = (32'd1 << w) - 32'd1;
    val = 32'd0;
    all_valid = 1'b1;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      all_valid = all_valid & rdv_a[k];
      val = val | ((32'(rd_a[k]) & m) << (b * w));
      tick();
    end
  endtask

  initial begin
    logic        seen;
    logic        allv;
    logic        acc;
    logic        err_first;
    logic [31:0] val;
    int          cnt;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0; we_a[k] = 1'b0; ack_a[k] = 1'b0; err_a[k] = 1'b0;
      f3_a[k] = 3'd0; rs1_a[k] = 4'd0; imm_a[k] = 4'd0; rs2_a[k] = 4'd0;
      rdt_a[k] = 32'd0;
    end
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state_%0d", k),
          {25'd0, busy_a[k], done_a[k], cyc_a[k], rdv_a[k], mis_a[k], berr_a[k], |rd_a[k]},
          32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Signed byte load, W=1, lane 3.
    exp_q.push_back(32'h0000_1000);
    exp_q.push_back(32'h0000_0008);
    exp_q.push_back(32'hFFFF_FF80);
    drive_op(0, 1'b0, 3'b000, 32'h1000, 32'd3, 32'd0, seen);
    chk("t1_no_cyc_in_addr", 32'(seen), 32'd0);
    @(negedge clk);
    chk("t1_cyc", 32'(cyc_a[0]), 32'd1);
    chk_pop("t1_adr", adr_a[0]);
    chk_pop("t1_sel", 32'(sel_a[0]));
    chk("t1_we", 32'(wwe_a[0]), 32'd0);
    tick();
    respond(0, 1'b1, 1'b0, 32'h8011_2233);
    collect(0, val, allv);
    chk("t1_rd_valid_all", 32'(allv), 32'd1);
    chk_pop("t1_rd", val);
    @(negedge clk);
    chk("t1_done", 32'(done_a[0]), 32'd1);
    chk("t1_rd_idle", {27'd0, rdv_a[0], rd_a[0]}, 32'd0);
    tick();
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done_a[0]), 32'd0);
    tick();

    // Half store, W=4, adr[1]=1.
    exp_q.push_back(32'h0000_000C);
    exp_q.push_back(32'hBEEF_BEEF);
    exp_q.push_back(32'h0000_2000);
    drive_op(1, 1'b1, 3'b001, 32'h2000, 32'd2, 32'h0000_BEEF, seen);
    chk("t2_no_cyc_before_8", 32'(seen), 32'd0);
    @(negedge clk);
    chk("t2_cyc_at_8", 32'(cyc_a[1]), 32'd1);
    chk_pop("t2_sel", 32'(sel_a[1]));
    chk_pop("t2_dat", dat_a[1]);
    chk_pop("t2_adr", adr_a[1]);
    chk("t2_we", 32'(wwe_a[1]), 32'd1);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t2_cyc_held", 32'(cyc_a[1]), 32'd1);
    tick();
    respond(1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("t2_done_cyc_busy", {29'd0, done_a[1], cyc_a[1], busy_a[1]}, 32'h4);
    tick();

    // Misaligned word, W=2.
    drive_op(2, 1'b0, 3'b010, 32'h100, 32'd1, 32'd0, seen);
    @(negedge clk);
    chk("t3_mis_done", {30'd0, mis_a[2], done_a[2]}, 32'h3);
    chk("t3_no_cyc", {30'd0, seen, cyc_a[2]}, 32'd0);
    chk("t3_busy", 32'(busy_a[2]), 32'd0);
    tick();
    tick();
    @(negedge clk);
    chk("t3_mis_hold", {30'd0, mis_a[2], done_a[2]}, 32'h2);
    tick();

    // Signed byte load, W=2, lane 1; new start clears misalign.
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0000_0002);
    exp_q.push_back(32'hFFFF_FFB3);
    drive_op(2, 1'b0, 3'b000, 32'h100, 32'd1, 32'd0, seen);
    @(negedge clk);
    chk("t3b_mis_cleared", 32'(mis_a[2]), 32'd0);
    chk_pop("t3b_adr", adr_a[2]);
    chk_pop("t3b_sel", 32'(sel_a[2]));
    tick();
    respond(2, 1'b1, 1'b0, 32'h1122_B344);
    collect(2, val, allv);
    chk("t3b_rd_valid_all", 32'(allv), 32'd1);
    chk_pop("t3b_rd", val);
    @(negedge clk);
    chk("t3b_done", 32'(done_a[2]), 32'd1);
    tick();

    // Ack and err together: err wins, no result phase.
    drive_op(1, 1'b0, 3'b010, 32'h40, 32'd0, 32'd0, seen);
    respond(1, 1'b1, 1'b1, 32'h5555_AAAA);
    @(negedge clk);
    chk("t4_err_done", {30'd0, berr_a[1], done_a[1]}, 32'h3);
    chk("t4_cyc_low", 32'(cyc_a[1]), 32'd0);
    acc = rdv_a[1];
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      acc = acc | rdv_a[1];
    end
    chk("t4_no_rd_valid", 32'(acc), 32'd0);
    chk("t4_err_hold", 32'(berr_a[1]), 32'd1);
    tick();

    // Timeout, W=4 TIMEOUT=16, no ack.
    drive_op(1, 1'b0, 3'b000, 32'h10, 32'd0, 32'd0, seen);
    cnt = 0;
    err_first = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) err_first = berr_a[1];
      if (!cyc_a[1]) break;
      cnt++;
      tick();
    end
    chk("t5_err_cleared_by_start", 32'(err_first), 32'd0);
    chk("t5_cyc_cycles", 32'(cnt), 32'd16);
    chk("t5_err_done", {30'd0, berr_a[1], done_a[1]}, 32'h3);
    tick();

    // Unsigned half load with carry through the address add; second start ignored.
    exp_q.push_back(32'h0000_3000);
    exp_q.push_back(32'h0000_000C);
    exp_q.push_back(32'h0000_F00D);
    drive_op(1, 1'b0, 3'b101, 32'h2FFF, 32'd3, 32'd0, seen);
    @(negedge clk);
    chk_pop("t7_adr", adr_a[1]);
    chk_pop("t7_sel", 32'(sel_a[1]));
    tick();
    respond(1, 1'b1, 1'b0, 32'hF00D_8001);
    start_a[1] = 1'b1;
    rs1_a[1]   = 4'hF;
    collect(1, val, allv);
    start_a[1] = 1'b0;
    rs1_a[1]   = 4'd0;
    chk("t7_rd_valid_all", 32'(allv), 32'd1);
    chk_pop("t7_rd", val);
    @(negedge clk);
    chk("t7_done", 32'(done_a[1]), 32'd1);
    tick();
    @(negedge clk);
    chk("t7_restart_ignored", {30'd0, busy_a[1], cyc_a[1]}, 32'd0);
    tick();

    // Word store with address wrap, then reset during BUS and a late ack.
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h0000_000F);
    exp_q.push_back(32'h1234_5678);
    drive_op(0, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'h201, 32'h1234_5678, seen);
    @(negedge clk);
    chk("t6_cyc", 32'(cyc_a[0]), 32'd1);
    chk_pop("t6_adr", adr_a[0]);
    chk_pop("t6_sel", 32'(sel_a[0]));
    chk_pop("t6_dat", dat_a[0]);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after_reset", {29'd0, cyc_a[0], busy_a[0], done_a[0]}, 32'd0);
    tick();
    ack_a[0] = 1'b1;
    tick();
    ack_a[0] = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acc = acc | done_a[0] | busy_a[0] | cyc_a[0] | rdv_a[0];
      tick();
    end
    chk("t6_late_ack_ignored", 32'(acc), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
